// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive checker on the active-low intersection LED bus.
// Decodes the lamp pattern to a phase, filters skew glitches, measures dwell in
// slow ticks and flags illegal patterns, illegal transitions and short dwells.
module traffic_light_monitor #(
  parameter int unsigned STABLE_CYC = 16,
  parameter int unsigned G_MIN      = 2,
  parameter int unsigned Y_MIN      = 1,
  parameter int unsigned P_MIN      = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] led_n,
  input  logic       tick,
  input  logic       clr_err,
  output logic [2:0] phase,
  output logic       phase_chg,
  output logic       seq_err,
  output logic [1:0] err_code,
  output logic [7:0] ped_count,
  output logic [7:0] last_dwell
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYC + 1);
  localparam int unsigned DW_W  = 8;

  typedef enum logic [2:0] {
    PH_INVALID = 3'd0,
    PH_C1_Y    = 3'd1,
    PH_C1_G    = 3'd2,
    PH_DARK    = 3'd3,
    PH_C2_Y    = 3'd4,
    PH_C2_G    = 3'd5,
    PH_P_G     = 3'd7
  } phase_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_PAT   = 2'd1;
  localparam logic [1:0] ERR_TRANS = 2'd2;
  localparam logic [1:0] ERR_DWELL = 2'd3;

  logic [7:0]      r_sync1;
  logic [7:0]      r_sync2;
  logic [7:0]      r_prev;
  logic [CNT_W-1:0] r_cnt;
  phase_e          r_phase;
  phase_e          r_ped_ret;
  logic            r_chg;
  logic            r_seq_err;
  logic [1:0]      r_err_code;
  logic [7:0]      r_ped;
  logic [DW_W-1:0] r_last;
  logic [DW_W-1:0] r_dwell;

  logic [7:0]      w_pat;
  phase_e          w_cand;
  logic            w_accept;
  logic [DW_W-1:0] w_dwell_exit;
  logic            w_legal;
  logic            w_short;
  logic [1:0]      w_err;

  // Pattern to phase code; anything unrecognised is INVALID.
  function automatic phase_e decode(input logic [7:0] p);
    case (p)
      8'b0000_0000: decode = PH_DARK;
      8'b1010_0001: decode = PH_C1_G;
      8'b1010_0010: decode = PH_C1_Y;
      8'b1000_1100: decode = PH_C2_G;
      8'b1001_0100: decode = PH_C2_Y;
      8'b0110_0100: decode = PH_P_G;
      default:      decode = PH_INVALID;
    endcase
  endfunction

  assign w_pat    = ~r_sync2;
  assign w_cand   = decode(r_prev);
  assign w_accept = (r_cnt == CNT_W'(STABLE_CYC)) && (w_cand != r_phase);

  // Dwell of the exiting phase, including a tick that lands on the acceptance clk.
  always_comb begin
    w_dwell_exit = r_dwell;
    if (tick && (r_dwell != {DW_W{1'b1}})) w_dwell_exit = r_dwell + DW_W'(1);
  end

  // Transition legality, short-dwell test and prioritised error code.
  always_comb begin
    w_legal = 1'b0;
    w_short = 1'b0;
    w_err   = ERR_NONE;
    if (w_cand == PH_DARK || r_phase == PH_INVALID) begin
      w_legal = 1'b1;
    end else begin
      case (r_phase)
        PH_DARK: w_legal = (w_cand == PH_C1_G);
        PH_C1_G: w_legal = (w_cand == PH_C1_Y);
        PH_C1_Y: w_legal = (w_cand == PH_C2_G) || (w_cand == PH_P_G);
        PH_C2_G: w_legal = (w_cand == PH_C2_Y);
        PH_C2_Y: w_legal = (w_cand == PH_C1_G) || (w_cand == PH_P_G);
        PH_P_G:  w_legal = (w_cand == r_ped_ret);
        default: w_legal = 1'b0;
      endcase
    end
    case (r_phase)
      PH_C1_G, PH_C2_G: w_short = (w_dwell_exit < DW_W'(G_MIN));
      PH_C1_Y, PH_C2_Y: w_short = (w_dwell_exit < DW_W'(Y_MIN));
      PH_P_G:           w_short = (w_dwell_exit < DW_W'(P_MIN));
      default:          w_short = 1'b0;
    endcase
    if (w_cand == PH_INVALID) w_err = ERR_PAT;
    else if (w_short)         w_err = ERR_DWELL;
    else if (!w_legal)        w_err = ERR_TRANS;
  end

  // Synchronizer and stability counter for the asynchronous LED bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 8'hFF;
      r_sync2 <= 8'hFF;
      r_prev  <= 8'h00;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= led_n;
      r_sync2 <= r_sync1;
      r_prev  <= w_pat;
      if (w_pat != r_prev)                r_cnt <= CNT_W'(1);
      else if (r_cnt != CNT_W'(STABLE_CYC)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Phase state, dwell measurement, pedestrian bookkeeping and error latching.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase    <= PH_DARK;
      r_ped_ret  <= PH_INVALID;
      r_chg      <= 1'b0;
      r_seq_err  <= 1'b0;
      r_err_code <= ERR_NONE;
      r_ped      <= 8'h00;
      r_last     <= '0;
      r_dwell    <= '0;
    end else begin
      r_chg <= w_accept;
      if (w_accept) begin
        r_phase <= w_cand;
        r_last  <= w_dwell_exit;
        r_dwell <= '0;
        if (w_cand == PH_P_G) begin
          r_ped     <= r_ped + 8'd1;
          r_ped_ret <= r_phase;
        end
      end else if (tick && (r_dwell != {DW_W{1'b1}})) begin
        r_dwell <= r_dwell + DW_W'(1);
      end
      if (w_accept && (w_err != ERR_NONE)) begin
        r_seq_err <= 1'b1;
        if (!r_seq_err || clr_err) r_err_code <= w_err;
      end else if (clr_err) begin
        r_seq_err  <= 1'b0;
        r_err_code <= ERR_NONE;
      end
    end
  end

  assign phase      = r_phase;
  assign phase_chg  = r_chg;
  assign seq_err    = r_seq_err;
  assign err_code   = r_err_code;
  assign ped_count  = r_ped;
  assign last_dwell = r_last;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: each directed pattern pushes the
// expected post-change status; a monitor pops and compares on every phase_chg.
module tb_traffic_light_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] led_n = 8'hFF;
  logic       tick = 1'b0;
  logic       clr_err = 1'b0;
  logic [2:0] phase;
  logic       phase_chg;
  logic       seq_err;
  logic [1:0] err_code;
  logic [7:0] ped_count;
  logic [7:0] last_dwell;

  localparam logic [7:0] P_DARK = 8'h00;
  localparam logic [7:0] P_C1G  = 8'hA1;
  localparam logic [7:0] P_C1Y  = 8'hA2;
  localparam logic [7:0] P_C2G  = 8'h8C;
  localparam logic [7:0] P_C2Y  = 8'h94;
  localparam logic [7:0] P_PG   = 8'h64;
  localparam logic [7:0] P_BAD  = 8'hFF;

  typedef struct packed {
    logic [2:0] ph;
    logic       se;
    logic [1:0] ec;
    logic [7:0] ped;
    logic [7:0] ld;
  } exp_t;

  exp_t q[$];
  exp_t m_exp;
  exp_t m_act;
  int   n_tests = 0;
  int   n_fail  = 0;

  traffic_light_monitor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .led_n      (led_n),
    .tick       (tick),
    .clr_err    (clr_err),
    .phase      (phase),
    .phase_chg  (phase_chg),
    .seq_err    (seq_err),
    .err_code   (err_code),
    .ped_count  (ped_count),
    .last_dwell (last_dwell)
  );

  always #5 clk = ~clk;

  // Monitor: every phase change must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && phase_chg !== 1'b0) begin
      n_tests++;
      m_act = {phase, seq_err, err_code, ped_count, last_dwell};
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_phase_chg: got phase=%0d err=%0d, required no change", phase, err_code);
      end else begin
        m_exp = q.pop_front();
        if (m_act !== m_exp) begin
          n_fail++;
          $display("FAIL phase_change: got ph=%0d se=%0d ec=%0d ped=%0d ld=%0d, required ph=%0d se=%0d ec=%0d ped=%0d ld=%0d",
                   m_act.ph, m_act.se, m_act.ec, m_act.ped, m_act.ld,
                   m_exp.ph, m_exp.se, m_exp.ec, m_exp.ped, m_exp.ld);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      next();
      tick = 1'b0;
      next();
    end
  endtask

  // Drive a pattern, expect one accepted change, then spend nt ticks in it.
  task automatic step(input string name, input logic [7:0] p,
                      input logic [2:0] ph, input logic se, input logic [1:0] ec,
                      input logic [7:0] ped, input logic [7:0] ld, input int nt);
    exp_t e;
    int   i;
    e = '{ph: ph, se: se, ec: ec, ped: ped, ld: ld};
    q.push_back(e);
    led_n = ~p;
    i = 0;
    while (q.size() != 0 && i < 40) begin
      next();
      i++;
    end
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got no phase_chg in %0d clks, required one", name, i);
      q.delete();
    end
    repeat (3) next();
    do_ticks(nt);
  endtask

  task automatic clear_and_check(input string name);
    clr_err = 1'b1;
    next();
    clr_err = 1'b0;
    chk({name, "_seq_err"}, 32'(seq_err), 32'd0);
    chk({name, "_err_code"}, 32'(err_code), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) next();
    chk("rst_phase", 32'(phase), 32'd3);
    chk("rst_chg", 32'(phase_chg), 32'd0);
    chk("rst_seq_err", 32'(seq_err), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_ped", 32'(ped_count), 32'd0);
    chk("rst_ld", 32'(last_dwell), 32'd0);
    rst_n = 1'b1;
    led_n = ~P_DARK;
    repeat (25) next();

    // Normal cycle
    step("t1_c1g", P_C1G, 3'd2, 1'b0, 2'd0, 8'd0, 8'd0, 2);
    step("t1_c1y", P_C1Y, 3'd1, 1'b0, 2'd0, 8'd0, 8'd2, 1);
    step("t1_c2g", P_C2G, 3'd5, 1'b0, 2'd0, 8'd0, 8'd1, 2);
    step("t1_c2y", P_C2Y, 3'd4, 1'b0, 2'd0, 8'd0, 8'd2, 1);
    step("t1_c1g2", P_C1G, 3'd2, 1'b0, 2'd0, 8'd0, 8'd1, 2);

    // Pedestrian phase returning to the interrupted yellow
    step("t2_c1y", P_C1Y, 3'd1, 1'b0, 2'd0, 8'd0, 8'd2, 1);
    step("t2_pg", P_PG, 3'd7, 1'b0, 2'd0, 8'd1, 8'd1, 7);
    step("t2_c1y2", P_C1Y, 3'd1, 1'b0, 2'd0, 8'd1, 8'd7, 1);
    step("t2_c2g", P_C2G, 3'd5, 1'b0, 2'd0, 8'd1, 8'd1, 2);

    // Illegal pattern, clear, recovery
    step("t3_bad", P_BAD, 3'd0, 1'b1, 2'd1, 8'd1, 8'd2, 0);
    repeat (20) next();
    clear_and_check("t3_clr");
    step("t3_c2y", P_C2Y, 3'd4, 1'b0, 2'd0, 8'd1, 8'd0, 1);
    step("t3_c1g", P_C1G, 3'd2, 1'b0, 2'd0, 8'd1, 8'd1, 2);

    // Illegal transition, first error held, then short dwell
    step("t4_c2g", P_C2G, 3'd5, 1'b1, 2'd2, 8'd1, 8'd2, 2);
    step("t4_c1g", P_C1G, 3'd2, 1'b1, 2'd2, 8'd1, 8'd2, 1);
    clear_and_check("t4_clr");
    step("t4_c1y", P_C1Y, 3'd1, 1'b1, 2'd3, 8'd1, 8'd1, 1);
    clear_and_check("t4_clr2");

    // Short glitch inside C1_G is ignored and dwell keeps counting
    step("t5_c2g", P_C2G, 3'd5, 1'b0, 2'd0, 8'd1, 8'd1, 2);
    step("t5_c2y", P_C2Y, 3'd4, 1'b0, 2'd0, 8'd1, 8'd2, 1);
    step("t5_c1g", P_C1G, 3'd2, 1'b0, 2'd0, 8'd1, 8'd1, 1);
    led_n = ~P_C1Y;
    repeat (14) next();
    led_n = ~P_C1G;
    repeat (30) next();
    chk("t5_phase", 32'(phase), 32'd2);
    chk("t5_seq_err", 32'(seq_err), 32'd0);
    do_ticks(1);
    step("t5_c1y", P_C1Y, 3'd1, 1'b0, 2'd0, 8'd1, 8'd2, 1);

    // Reach ped_count=3, then reset in P_G
    step("t6_pg", P_PG, 3'd7, 1'b0, 2'd0, 8'd2, 8'd1, 7);
    step("t6_c1y", P_C1Y, 3'd1, 1'b0, 2'd0, 8'd2, 8'd7, 1);
    step("t6_c2g", P_C2G, 3'd5, 1'b0, 2'd0, 8'd2, 8'd1, 2);
    step("t6_c2y", P_C2Y, 3'd4, 1'b0, 2'd0, 8'd2, 8'd2, 1);
    step("t6_pg2", P_PG, 3'd7, 1'b0, 2'd0, 8'd3, 8'd1, 2);
    rst_n = 1'b0;
    led_n = ~P_C2G;
    #1;
    chk("t6_rst_phase", 32'(phase), 32'd3);
    chk("t6_rst_ped", 32'(ped_count), 32'd0);
    chk("t6_rst_ld", 32'(last_dwell), 32'd0);
    chk("t6_rst_seq_err", 32'(seq_err), 32'd0);
    next();
    rst_n = 1'b1;
    step("t6_c2g_after_rst", P_C2G, 3'd5, 1'b1, 2'd2, 8'd0, 8'd0, 0);

    repeat (30) next();
    chk("final_queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
